// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Optional feature macro: MULTDIV_FAST_MULT_EN (single-cycle MULT path).
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_t;

endpackage : multdiv_pkg

// File: rtl/md_step.sv
// One combinational iteration of the magnitude datapath.
// MULT: shift-add step, {acc, sreg} holds the running product with the
//       remaining multiplier bits in the low end of sreg.
// DIV:  restoring-subtract step, acc is the partial remainder and sreg
//       shifts dividend bits out while quotient bits shift in.
// Optional feature macro: MULTDIV_FAST_MULT_EN (handled in the top level).
module md_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_t             op_i,
    input  logic [WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]   sreg_i,
    input  logic [WIDTH-1:0]   b_mag_i,
    output logic [WIDTH-1:0]   acc_o,
    output logic [WIDTH-1:0]   sreg_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Single shift-add or restoring-subtract step on unsigned magnitudes.
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path
        // through the branches below can infer a latch.
        acc_o   = acc_i;
        sreg_o  = sreg_i;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (op_i == OP_MULT) begin
            sum = {1'b0, acc_i} + (sreg_i[0] ? {1'b0, b_mag_i} : '0);
            {acc_o, sreg_o} = {sum, sreg_i[WIDTH-1:1]};
        end else begin
            shifted = {acc_i, sreg_i[WIDTH-1]};
            // One extra bit so the borrow out of the trial subtract is visible.
            diff = {1'b0, shifted} - {2'b00, b_mag_i};
            if (!diff[WIDTH+1]) begin
                acc_o  = diff[WIDTH-1:0];
                sreg_o = {sreg_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o  = shifted[WIDTH-1:0];
                sreg_o = {sreg_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule : md_step

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with HI/LO result registers.
// A start request latches operands; WIDTH shift-add / restoring-subtract
// steps run on magnitudes, then a fixup cycle applies signs and commits
// HI/LO. busy covers the whole operation, done pulses once after commit.
// Optional feature macro: MULTDIV_FAST_MULT_EN -- MULT bypasses the
// iterative phase with a single-cycle signed product.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             multdiv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_t           op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             neg_q, neg_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_acc, step_sreg;
    logic [2*WIDTH-1:0] product;

    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag   = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign product = {acc_q, sreg_q};

    md_step #(.WIDTH(WIDTH)) u_step (
        .op_i    (op_q),
        .acc_i   (acc_q),
        .sreg_i  (sreg_q),
        .b_mag_i (b_mag_q),
        .acc_o   (step_acc),
        .sreg_o  (step_sreg)
    );

    // Next-state, datapath and HI/LO commit logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        b_zero_d = b_zero_q;
        a_d      = a_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        sreg_d   = sreg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = md_op_t'(multdiv);
                    sign_a_d = a[WIDTH-1];
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    b_zero_d = (b == '0);
                    a_d      = a;
                    b_mag_d  = b_mag;
                    acc_d    = '0;
                    sreg_d   = a_mag;
                    cnt_d    = '0;
                    if (multdiv && (b == '0)) begin
                        state_d = FIX;
`ifdef MULTDIV_FAST_MULT_EN
                    end else if (!multdiv) begin
                        {acc_d, sreg_d} = $signed({{WIDTH{a[WIDTH-1]}}, a})
                                        * $signed({{WIDTH{b[WIDTH-1]}}, b});
                        state_d = FIX;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d  = step_acc;
                sreg_d = step_sreg;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q == OP_MULT) begin
`ifdef MULTDIV_FAST_MULT_EN
                    {hi_d, lo_d} = product;
`else
                    {hi_d, lo_d} = neg_q ? (~product + 1'b1) : product;
`endif
                end else if (b_zero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_q    ? (~sreg_q + 1'b1) : sreg_q;
                    hi_d = sign_a_q ? (~acc_q + 1'b1)  : acc_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            sreg_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            b_zero_q <= b_zero_d;
            a_q      <= a_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            sreg_q   <= sreg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH = 32).
// Optional feature macro: MULTDIV_FAST_MULT_EN changes the expected MULT latency.
module tb_mult_div_unit;

    localparam int W   = 32;
    localparam int LIM = 100;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         multdiv;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int n_pushed  = 0;
    logic [2*W-1:0] sb_q[$];

    typedef struct {
        logic         op;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .multdiv (multdiv),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: signed product, truncating division, spec'd corner cases.
    function automatic logic [63:0] model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] p;
        logic signed [W-1:0] sx, sy, q, r;
        sx = x;
        sy = y;
        if (!op) begin
            p = sx * sy;
            return p;
        end
        if (y == '0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
    endfunction

    // Scoreboard: every done pulse pops one expected HI/LO pair.
    always @(posedge clk) begin
        #1;
        if (reset === 1'b0 && done === 1'b1) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
                check("hilo", {hi, lo}, sb_q.pop_front());
            end
        end
    end

    // Launch one op and follow it to done, checking busy and latency.
    // inj > 0 pulses start with DIV 9/3 in that cycle, which must be ignored.
    task automatic run_op(input logic op_v, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [63:0] exp_v, input int inj);
        int n;
        int lat;
        lat = 34;
        if (op_v && bv == '0) lat = 2;
`ifdef MULTDIV_FAST_MULT_EN
        if (!op_v) lat = 2;
`endif
        @(negedge clk);
        start = 1'b1; multdiv = op_v; a = av; b = bv;
        sb_q.push_back(exp_v);
        n_pushed++;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < LIM) begin
            check("busy_in_flight", 64'(busy), 64'(1));
            if (n == inj) begin
                @(negedge clk);
                start = 1'b1; multdiv = 1'b1; a = 32'd9; b = 32'd3;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        check("done_latency", 64'(n), 64'(lat));
        check("busy_at_done", 64'(busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{1'b1, 32'd100,        32'd7,         32'h0000_0002, 32'h0000_000E};
        vecs[2] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{1'b1, 32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{1'b0, 32'h7FFF_FFFF,  32'd2,         32'h0000_0000, 32'hFFFF_FFFE};

        reset = 1'b1; start = 1'b0; multdiv = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi",   64'(hi),   64'(0));
        check("reset_lo",   64'(lo),   64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Table vectors, launched back-to-back in each done cycle.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv, {vecs[i].ehi, vecs[i].elo}, 0);
        end

        // Random operands against the reference model.
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rop;
            ra  = $urandom;
            rb  = (i == 2) ? 32'd0 : $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300));
            rop = 1'(i % 2);
            run_op(rop, ra, rb, model(rop, ra, rb), 0);
        end

        // start while busy is ignored: MULT 3*4 with DIV 9/3 pulsed in cycle 5.
        run_op(1'b0, 32'd3, 32'd4, {32'h0, 32'h0000_000C}, 5);
        repeat (40) @(posedge clk);

        // Reset in cycle 10 of DIV 50/5 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; multdiv = 1'b1; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hi",   64'(hi),   64'(0));
        check("abort_lo",   64'(lo),   64'(0));
        check("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        run_op(1'b0, 32'd2, 32'd2, {32'h0, 32'h0000_0004}, 0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        check("done_count", 64'(done_seen), 64'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_div_unit
